// File: rtl/mem_bus_pkg.sv
// Shared types for the byte-serial memory bus sequencer: FSM states,
// command-byte layout and the per-byte wait counter width.
package mem_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COMMAND,
        ST_ADDRESS,
        ST_DATA,
        ST_DONE
    } state_e;

    // Command byte: MSB selects store (1) or load (0); the rest is reserved zero.
    typedef struct packed {
        logic       write;
        logic [6:0] rsvd;
    } cmd_byte_t;

    localparam int WAIT_W     = 8;
    localparam int DATA_BYTES = 4;

endpackage

// File: rtl/mem_bus_sequencer_if.sv
// CPU request/response and external byte-bus signals of the sequencer.
interface mem_bus_sequencer_if;
    logic        req_valid;
    logic        req_write;
    logic [31:0] req_address;
    logic [31:0] req_write_data;
    logic        req_ready;
    logic [31:0] req_read_data;
    logic        req_error;
    logic        stall;
    logic [7:0]  bus_out;
    logic [7:0]  bus_oe;
    logic        bus_strobe;
    logic [7:0]  bus_in;
    logic        bus_ack;

    modport slave (
        input  req_valid, req_write, req_address, req_write_data, bus_in, bus_ack,
        output req_ready, req_read_data, req_error, stall, bus_out, bus_oe, bus_strobe
    );

    modport master (
        output req_valid, req_write, req_address, req_write_data, bus_in, bus_ack,
        input  req_ready, req_read_data, req_error, stall, bus_out, bus_oe, bus_strobe
    );
endinterface

// File: rtl/bus_byte_timer.sv
// Per-byte wait counter; expired flags the TIMEOUT-th consecutive cycle
// spent waiting for an acknowledge.
module bus_byte_timer
    import mem_bus_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic count_enable,
    output logic expired
);

    logic [WAIT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear)
            count_d = '0;
        else if (count_enable)
            count_d = count_q + 1'b1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) count_q <= '0;
        else          count_q <= count_d;
    end

    // count_enable already excludes ack, so an ack in the same cycle wins.
    assign expired = count_enable && (count_q == WAIT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_bus_sequencer.sv
// Turns one CPU load/store into a command, address and data byte exchange
// on an acknowledged 8-bit bus, aborting with an error on a per-byte timeout.
module mem_bus_sequencer
    import mem_bus_pkg::*;
#(
    parameter int ADDR_BYTES = 2,
    parameter int TIMEOUT    = 255
) (
    input  logic               clock,
    input  logic               reset_n,
    mem_bus_sequencer_if.slave bus
);

    state_e      state_q, state_d;
    logic        write_q, write_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        err_q, err_d;

    logic        strobe, oe_en, byte_done, timed_out, timer_clear, timer_en, ready;
    logic [7:0]  tx_byte;
    cmd_byte_t   cmd;

    assign strobe    = (state_q == ST_COMMAND) || (state_q == ST_ADDRESS) || (state_q == ST_DATA);
    assign byte_done = strobe && bus.bus_ack;
    assign timer_en  = strobe && !bus.bus_ack;
    assign timer_clear = byte_done || (state_d != state_q);

    bus_byte_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clock        (clock),
        .reset_n      (reset_n),
        .clear        (timer_clear),
        .count_enable (timer_en),
        .expired      (timed_out)
    );

    always_comb begin
        state_d = state_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: if (bus.req_valid) begin
                write_d = bus.req_write;
                addr_d  = bus.req_address;
                wdata_d = bus.req_write_data;
                rdata_d = '0;
                err_d   = 1'b0;
                cnt_d   = '0;
                state_d = ST_COMMAND;
            end
            ST_COMMAND: if (byte_done) state_d = ST_ADDRESS;
            ST_ADDRESS: if (byte_done) begin
                if (cnt_q == 2'(ADDR_BYTES - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_DATA;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            ST_DATA: if (byte_done) begin
                if (!write_q) rdata_d[{cnt_q, 3'b000} +: 8] = bus.bus_in;
                if (cnt_q == 2'(DATA_BYTES - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (timed_out) begin
            state_d = ST_DONE;
            err_d   = 1'b1;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Bus-side outputs depend only on registers, never on bus_in/bus_ack.
    assign cmd = cmd_byte_t'{write: write_q, rsvd: 7'b0};

    always_comb begin
        tx_byte = 8'h00;
        case (state_q)
            ST_COMMAND: tx_byte = cmd;
            ST_ADDRESS: tx_byte = addr_q[{cnt_q, 3'b000} +: 8];
            ST_DATA:    tx_byte = wdata_q[{cnt_q, 3'b000} +: 8];
            default:    tx_byte = 8'h00;
        endcase
    end

    assign oe_en = (state_q == ST_COMMAND) || (state_q == ST_ADDRESS) ||
                   ((state_q == ST_DATA) && write_q);
    assign ready = (state_q == ST_DONE);

    assign bus.bus_strobe    = strobe;
    assign bus.bus_oe        = {8{oe_en}};
    assign bus.bus_out       = oe_en ? tx_byte : 8'h00;
    assign bus.req_ready     = ready;
    assign bus.req_error     = ready && err_q;
    assign bus.req_read_data = (ready && !err_q) ? rdata_q : 32'h0;
    assign bus.stall         = bus.req_valid && !ready;

endmodule

// File: tb/tb_mem_bus_sequencer.sv
// Bench for mem_bus_sequencer: byte-queue reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mem_bus_sequencer;

    localparam int AB   = 2;
    localparam int TO_A = 6;
    localparam int TO_B = 4;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    mem_bus_sequencer_if ifa();
    mem_bus_sequencer_if ifb();

    mem_bus_sequencer #(.ADDR_BYTES(AB), .TIMEOUT(TO_A)) dut (
        .clock(clock), .reset_n(reset_n), .bus(ifa));
    mem_bus_sequencer #(.ADDR_BYTES(AB), .TIMEOUT(TO_B)) dut_to (
        .clock(clock), .reset_n(reset_n), .bus(ifb));

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- external device for ifa ----------------
    int         ack_mode  = 0;   // 0: always ack, 1: ack after ack_delay waits, 2: random
    int         ack_delay = 0;
    int         dcnt = 0;
    int         dridx = 0;
    logic [7:0] dev_tab [4];

    always @(posedge clock) begin
        if (ifa.bus_strobe && ifa.bus_ack) begin
            dcnt = 0;
            if (ifa.bus_oe == 8'h00) dridx++;
        end else if (ifa.bus_strobe) begin
            dcnt++;
        end else begin
            dcnt  = 0;
            dridx = 0;
        end
        #1;
        case (ack_mode)
            0:       ifa.bus_ack = 1'b1;
            1:       ifa.bus_ack = (dcnt >= ack_delay);
            default: ifa.bus_ack = ($urandom_range(0, 2) == 0);
        endcase
        ifa.bus_in = (ack_mode == 2) ? 8'($urandom) : dev_tab[dridx & 3];
    end

    // ---------------- reference model (byte queue per transaction) ----------------
    typedef struct {
        bit         oe;
        logic [7:0] val;
        bit         rd;
        int         k;
    } mbyte_t;

    mbyte_t      mq[$];
    bit          m_busy, m_done, m_err;
    int          m_wait;
    logic [31:0] m_rdata;
    logic [7:0]  log_out[$];
    bit          log_oe[$];

    always @(negedge clock) begin
        if (!reset_n) begin
            m_busy = 0; m_done = 0; m_err = 0; m_wait = 0; m_rdata = '0;
            mq.delete();
            chk("rst_strobe", {31'b0, ifa.bus_strobe}, 0);
            chk("rst_oe",     {24'b0, ifa.bus_oe}, 0);
            chk("rst_out",    {24'b0, ifa.bus_out}, 0);
            chk("rst_ready",  {31'b0, ifa.req_ready}, 0);
            chk("rst_error",  {31'b0, ifa.req_error}, 0);
            chk("rst_rdata",  ifa.req_read_data, 0);
        end else begin
            chk("strobe", {31'b0, ifa.bus_strobe}, {31'b0, m_busy});
            chk("oe",     {24'b0, ifa.bus_oe}, (m_busy && mq[0].oe) ? 32'hFF : 32'h0);
            chk("out",    {24'b0, ifa.bus_out}, m_busy ? {24'b0, mq[0].val} : 32'h0);
            chk("ready",  {31'b0, ifa.req_ready}, {31'b0, m_done});
            chk("stall",  {31'b0, ifa.stall}, {31'b0, ifa.req_valid && !m_done});
            if (m_done) begin
                chk("error", {31'b0, ifa.req_error}, {31'b0, m_err});
                chk("rdata", ifa.req_read_data, m_err ? 32'h0 : m_rdata);
            end
            // advance the model across the coming edge
            if (m_done) begin
                m_done = 0;
            end else if (!m_busy) begin
                if (ifa.req_valid) begin
                    m_busy = 1; m_wait = 0; m_rdata = '0;
                    mq.delete();
                    mq.push_back('{1'b1, {ifa.req_write, 7'b0}, 1'b0, 0});
                    for (int a = 0; a < AB; a++)
                        mq.push_back('{1'b1, ifa.req_address[8*a +: 8], 1'b0, 0});
                    for (int k = 0; k < 4; k++)
                        if (ifa.req_write) mq.push_back('{1'b1, ifa.req_write_data[8*k +: 8], 1'b0, k});
                        else               mq.push_back('{1'b0, 8'h00, 1'b1, k});
                end
            end else if (ifa.bus_ack) begin
                if (mq[0].rd) m_rdata[8*mq[0].k +: 8] = ifa.bus_in;
                log_out.push_back(mq[0].val);
                log_oe.push_back(mq[0].oe);
                void'(mq.pop_front());
                m_wait = 0;
                if (mq.size() == 0) begin m_busy = 0; m_done = 1; m_err = 0; end
            end else begin
                m_wait++;
                if (m_wait == TO_A) begin m_busy = 0; m_done = 1; m_err = 1; end
            end
        end
    end

    // ---------------- request driver ----------------
    task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input bit scramble, input bit hold,
                       output int lat, output logic err, output logic [31:0] rd);
        bit got = 0;
        int n = 0;
        ifa.req_valid = 1'b1; ifa.req_write = w;
        ifa.req_address = a;  ifa.req_write_data = d;
        err = 1'bx; rd = 'x;
        while (!got && n < 400) begin
            n++;
            @(negedge clock);
            if (ifa.req_ready) begin got = 1; err = ifa.req_error; rd = ifa.req_read_data; end
            @(posedge clock); #1;
            if (!got && scramble) begin
                ifa.req_valid = 1'($urandom);
                ifa.req_write = 1'($urandom);
                ifa.req_address = $urandom;
                ifa.req_write_data = $urandom;
            end
        end
        if (!got) begin
            checks++; fails++;
            $display("FAIL txn_wait: no req_ready within %0d cycles", n);
        end
        lat = n;
        if (!hold) ifa.req_valid = 1'b0;
    endtask

    logic [7:0] exp_b [7];

    initial begin
        int          lat, rc;
        logic        e;
        logic [31:0] rd;

        dev_tab[0] = 8'h11; dev_tab[1] = 8'h22; dev_tab[2] = 8'h33; dev_tab[3] = 8'h44;
        exp_b[0] = 8'h80; exp_b[1] = 8'h34; exp_b[2] = 8'h12; exp_b[3] = 8'hD4;
        exp_b[4] = 8'hC3; exp_b[5] = 8'hB2; exp_b[6] = 8'hA1;
        ifa.req_valid = 0; ifa.req_write = 0; ifa.req_address = 0; ifa.req_write_data = 0;
        ifb.req_valid = 0; ifb.req_write = 0; ifb.req_address = 0; ifb.req_write_data = 0;
        ifb.bus_ack = 0;   ifb.bus_in = 8'h5A;

        @(negedge clock);
        chk("rst_b_strobe", {31'b0, ifb.bus_strobe}, 0);
        chk("rst_b_oe",     {24'b0, ifb.bus_oe}, 0);
        chk("rst_b_ready",  {31'b0, ifb.req_ready}, 0);
        @(posedge clock); #1 reset_n = 1'b1;

        // store, ack tied high
        log_out.delete(); log_oe.delete();
        txn(1'b1, 32'h0000_1234, 32'hA1B2_C3D4, 0, 0, lat, e, rd);
        chk("store_latency", lat, 9);
        chk("store_error", {31'b0, e}, 0);
        chk("store_nbytes", log_out.size(), 7);
        if (log_out.size() == 7)
            for (int i = 0; i < 7; i++) chk("store_byte", {24'b0, log_out[i]}, {24'b0, exp_b[i]});

        // load, device supplies 11,22,33,44
        log_out.delete(); log_oe.delete();
        txn(1'b0, 32'h0000_0010, 32'h0, 0, 0, lat, e, rd);
        chk("load_rdata", rd, 32'h4433_2211);
        chk("load_error", {31'b0, e}, 0);
        chk("load_latency", lat, 9);
        if (log_oe.size() == 7)
            for (int i = 3; i < 7; i++) chk("load_data_oe", {31'b0, log_oe[i]}, 0);

        // store with a slow device: each byte spends 5 cycles on the bus
        ack_mode = 1; ack_delay = 4;
        txn(1'b1, 32'h0000_ABCD, 32'h0102_0304, 0, 0, lat, e, rd);
        chk("slow_latency", lat, 37);
        chk("slow_error", {31'b0, e}, 0);
        ack_mode = 0;

        // timeout on the command byte, TIMEOUT=4 instance
        ifb.req_valid = 1; ifb.req_write = 0; ifb.req_address = 32'h10;
        rc = 0;
        for (int n = 1; n <= 12 && rc == 0; n++) begin
            @(negedge clock);
            if (n == 2) chk("to_strobe", {31'b0, ifb.bus_strobe}, 1);
            if (ifb.req_ready) begin
                rc = n;
                chk("to_error", {31'b0, ifb.req_error}, 1);
                chk("to_rdata", ifb.req_read_data, 0);
            end
            @(posedge clock); #1;
            if (n == 1) ifb.req_valid = 0;
        end
        chk("to_latency", rc, 6);

        // reset in the middle of ADDRESS
        ifa.req_valid = 1; ifa.req_write = 1; ifa.req_address = 32'h5678; ifa.req_write_data = 32'hDEAD_BEEF;
        repeat (2) begin @(posedge clock); #1; end
        #1 reset_n = 1'b0;
        #1;
        chk("midrst_strobe", {31'b0, ifa.bus_strobe}, 0);
        chk("midrst_oe", {24'b0, ifa.bus_oe}, 0);
        ifa.req_valid = 0;
        @(posedge clock); #1 reset_n = 1'b1;
        txn(1'b1, 32'h0000_0042, 32'h5555_AAAA, 0, 0, lat, e, rd);
        chk("postrst_latency", lat, 9);
        chk("postrst_error", {31'b0, e}, 0);

        // back-to-back with req_valid held high
        txn(1'b1, 32'h0000_1111, 32'h2222_3333, 0, 1, lat, e, rd);
        chk("b2b_lat0", lat, 9);
        txn(1'b0, 32'h0000_4444, 32'h0, 0, 1, lat, e, rd);
        chk("b2b_lat1", lat, 9);
        chk("b2b_rdata1", rd, 32'h4433_2211);
        txn(1'b1, 32'h0000_5555, 32'h6666_7777, 0, 0, lat, e, rd);
        chk("b2b_lat2", lat, 9);

        // random traffic, random acks (timeouts included), fields scrambled after acceptance
        ack_mode = 2;
        for (int t = 0; t < 40; t++) begin
            bit hold;
            hold = 1'($urandom);
            txn(1'($urandom), $urandom, $urandom, 1, hold, lat, e, rd);
            if (!hold) repeat ($urandom_range(0, 2)) begin @(posedge clock); #1; end
        end
        ifa.req_valid = 0;
        repeat (3) @(posedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
